// File: rtl/ahfp_fixed_accumulator_if.sv
// Handshake bundle between a sample producer, the fixed-point accumulator
// and the result consumer. The master side drives the requests and the
// samples; the slave side is the accumulator.
interface ahfp_fixed_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic              busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/ahfp_fixed_accumulator.sv
// Sums a block of len signed Q3.29 samples into a guarded accumulator and
// returns the sum clipped to the Q3.29 range on a valid/ready output.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; no samples consumed, no result offered
// ACC   | accepting samples until len beats have been summed
// DONE  | result registered and offered until out_ready completes it
module ahfp_fixed_accumulator #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int GUARD  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  ahfp_fixed_accumulator_if.slave  bus
);

  localparam int ACC_W = DATA_W + GUARD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  len_q;

  logic [ACC_W-1:0]  acc_next;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] sat_data;
  logic              sat_flag;

  // Next accumulator value including the beat on the bus, and its clipped
  // DATA_W view. The bits from DATA_W-1 upward must all match for the sum
  // to be representable; otherwise the sign of acc picks the rail.
  always_comb begin
    acc_next   = acc + {{GUARD{bus.in_data[DATA_W-1]}}, bus.in_data};
    count_next = count + {{(CNT_W-1){1'b0}}, 1'b1};
    sat_data   = acc_next[DATA_W-1:0];
    sat_flag   = 1'b0;
    if (!((&acc_next[ACC_W-1:DATA_W-1]) || (~|acc_next[ACC_W-1:DATA_W-1]))) begin
      sat_flag = 1'b1;
      sat_data = acc_next[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Block sequencer; every output is a register so nothing glitches
  // toward the downstream consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      count         <= '0;
      len_q         <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc      <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            if (bus.len != '0) begin
              len_q        <= bus.len;
              bus.in_ready <= 1'b1;
              state        <= ACC;
            end else begin
              // Empty block: the result is an unclipped zero.
              bus.out_data  <= '0;
              bus.out_sat   <= 1'b0;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc   <= acc_next;
            count <= count_next;
            if (count_next == len_q) begin
              bus.in_ready  <= 1'b0;
              bus.out_data  <= sat_data;
              bus.out_sat   <= sat_flag;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahfp_fixed_accumulator.sv
// Scoreboard bench for ahfp_fixed_accumulator: the driver pushes the
// expected clipped sum for each block, a monitor pops it on every output
// handshake and also watches that a stalled result stays stable.
module tb_ahfp_fixed_accumulator;

  logic clk = 1'b0;
  logic reset;

  ahfp_fixed_accumulator_if #(.DATA_W(32), .CNT_W(8)) bus ();

  ahfp_fixed_accumulator #(.DATA_W(32), .CNT_W(8), .GUARD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   hold_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, then clip to the signed 32-bit range.
  function automatic exp_t model(input logic [31:0] s[$]);
    longint sum;
    exp_t   e;
    sum = 0;
    foreach (s[i]) sum += longint'(int'(s[i]));
    if (sum > 64'sd2147483647) begin
      e.data = 32'h7FFFFFFF;
      e.sat  = 1'b1;
    end else if (sum < -64'sd2147483648) begin
      e.data = 32'h80000000;
      e.sat  = 1'b1;
    end else begin
      e.data = sum[31:0];
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (bus.busy && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy got 1 expected 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed_beat(input logic [31:0] d, input int gap, inout int cyc);
    bit ok;
    int g;
    ok = 1'b0;
    g  = 0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!ok && g < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      g++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_accept: in_ready got 0 expected 1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [31:0] s[$], input int gap_lo, input int gap_hi,
                           input int hold, input bit poke);
    int n;
    int cyc;
    n = s.size();
    hold_cycles = hold;
    wait_idle();
    bus.start = 1'b1;
    bus.len   = 8'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.len   = 8'($urandom);
    cyc = 1;
    check("busy_after_start", 64'(bus.busy), 64'(1));
    foreach (s[i]) feed_beat(s[i], int'($urandom_range(gap_hi, gap_lo)), cyc);
    sb.push_back(model(s));
    check("valid_after_last", 64'(bus.out_valid), 64'(1));
    check("in_ready_in_done", 64'(bus.in_ready), 64'(0));
    if (gap_hi == 0) check("start_to_valid_cycles", 64'(cyc), 64'(n + 1));
    if (poke) begin
      bus.start = 1'b1;
      bus.len   = 8'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    wait_idle();
    if (poke) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        check("start_ignored_busy", 64'(bus.busy), 64'(0));
        check("start_ignored_ready", 64'(bus.in_ready), 64'(0));
      end
    end
  endtask

  // Result consumer: raises out_ready after hold_cycles of out_valid.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        if (wait_cnt >= hold_cycles) bus.out_ready = 1'b1;
        else wait_cnt++;
      end else begin
        bus.out_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  initial begin
    bit          held;
    logic [31:0] hd;
    logic        hs;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
        continue;
      end
      if (bus.out_valid && bus.in_ready) begin
        total++;
        bad++;
        $display("FAIL ready_valid_overlap: in_ready got 1 expected 0");
      end
      if (bus.out_valid) begin
        if (held) begin
          check("hold_data", 64'(bus.out_data), 64'(hd));
          check("hold_sat", 64'(bus.out_sat), 64'(hs));
        end
        if (bus.out_ready) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %h expected none", bus.out_data);
          end else begin
            e = sb.pop_front();
            check("result_data", 64'(bus.out_data), 64'(e.data));
            check("result_sat", 64'(bus.out_sat), 64'(e.sat));
          end
        end else begin
          held = 1'b1;
          hd   = bus.out_data;
          hs   = bus.out_sat;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL global_timeout: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] s[$];
    int cyc;
    int n;
    int mode;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_sat", 64'(bus.out_sat), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Samples offered in IDLE must not be consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000007;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid = 1'b0;

    s = '{32'h20000000};
    run_block(s, 0, 0, 0, 0);
    s = '{32'h20000000, 32'hE0000000};
    run_block(s, 0, 0, 1, 0);
    s = '{32'h20000000, 32'h20000000, 32'h20000000, 32'h20000000};
    run_block(s, 0, 0, 0, 0);
    s = '{32'hE0000000, 32'hE0000000, 32'hE0000000, 32'hE0000000};
    run_block(s, 0, 0, 2, 0);
    s = '{32'h11111111, 32'h02000000, 32'hF0000000};
    run_block(s, 2, 2, 3, 1);
    s = {};
    run_block(s, 0, 0, 0, 0);
    s = '{32'h40000000, 32'h3FFFFFFF};
    run_block(s, 0, 0, 0, 0);
    s = '{32'h40000000, 32'h40000000};
    run_block(s, 0, 0, 0, 0);
    s = {};
    for (int i = 0; i < 255; i++) s.push_back(32'h7FFFFFFF);
    run_block(s, 0, 0, 0, 0);
    s = {};
    for (int i = 0; i < 255; i++) s.push_back(32'h80000000);
    run_block(s, 0, 1, 1, 0);

    // Reset mid-block: everything clears, no result, next block starts clean.
    wait_idle();
    bus.start = 1'b1;
    bus.len   = 8'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    feed_beat(32'h20000000, 0, cyc);
    feed_beat(32'h20000000, 0, cyc);
    #2 reset = 1'b1;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'(0));
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_out_data", 64'(bus.out_data), 64'(0));
    check("abort_out_sat", 64'(bus.out_sat), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    s = '{32'h10000000};
    run_block(s, 0, 0, 0, 0);

    for (int b = 0; b < 40; b++) begin
      n    = ($urandom_range(5) == 0) ? int'($urandom_range(40, 9)) : int'($urandom_range(8, 0));
      mode = int'($urandom_range(2));
      s = {};
      for (int i = 0; i < n; i++) begin
        if (mode == 0) s.push_back($urandom);
        else if (mode == 1) s.push_back(32'(int'($urandom_range(32'h10000000)) - 32'h08000000));
        else s.push_back($urandom_range(1) ? 32'h20000000 : 32'hE0000000);
      end
      run_block(s, 0, int'($urandom_range(2)), int'($urandom_range(3)), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
